// File: rtl/rx_shift_register.sv
// Receive shifter of the SPI master: assembles char_len bits from miso into rx_data,
// in lock-step with the transmit shifter, and strobes rx_complete once per frame.
module rx_shift_register #(
   parameter int DATA_W = 128,
   parameter int CLEN_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CLEN_W-1:0] char_len,
   input  logic              lsb,
   input  logic              go_busy,
   input  logic              miso,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_complete,
   output logic              busy
);

   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, HOLD} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CLEN_W-1:0] cnt;
   logic [CLEN_W:0]   len;
   logic              lsb_q;
   logic [DATA_W-1:0] shadow;
   logic [DATA_W-1:0] shadow_nxt;
   logic [CLEN_W:0]   last_idx;
   logic [IDX_W-1:0]  bit_idx;
   logic              last_bit;
   logic              start;
   logic              capture;
   logic              finish;
   logic              busy_nxt;
   logic              complete_nxt;

   // A zero char_len naturally encodes the full 2^CLEN_W length via the extra MSB.
   assign last_idx = len - (CLEN_W+1)'(1);
   assign last_bit = ({1'b0, cnt} == last_idx);
   assign bit_idx  = lsb_q ? IDX_W'(cnt) : IDX_W'(last_idx - {1'b0, cnt});
   assign start    = (state == IDLE) && go_busy;
   assign capture  = (state == SHIFT) && go_busy;
   assign finish   = capture && last_bit;

   always_comb begin
      shadow_nxt          = shadow;
      shadow_nxt[bit_idx] = miso;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go_busy) state_nxt = SHIFT;
         SHIFT: begin
            if (!go_busy)     state_nxt = IDLE;
            else if (last_bit) state_nxt = DONE;
         end
         DONE:    state_nxt = go_busy ? HOLD : IDLE;
         HOLD:    if (!go_busy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_nxt     = (state_nxt == SHIFT);
      complete_nxt = finish;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= 1'b0;
         rx_complete <= 1'b0;
      end else begin
         busy        <= busy_nxt;
         rx_complete <= complete_nxt;
      end
   end

   // Length and bit order are frozen at the start edge; miso is not sampled then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len     <= '0;
         lsb_q   <= 1'b0;
         cnt     <= '0;
         shadow  <= '0;
         rx_data <= '0;
      end else begin
         if (start) begin
            len    <= {(char_len == '0), char_len};
            lsb_q  <= lsb;
            cnt    <= '0;
            shadow <= '0;
         end else if (capture) begin
            shadow <= shadow_nxt;
            cnt    <= cnt + CLEN_W'(1);
         end
         if (finish) begin
            rx_data <= shadow_nxt;
         end
      end
   end

endmodule

// File: tb/tb_rx_shift_register.sv
// Directed bench for rx_shift_register: bit order, full length, abort, hold and async reset.
module tb_rx_shift_register;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [5:0]   char_len = '0;
   logic         lsb = 1'b0;
   logic         go_busy = 1'b0;
   logic         miso = 1'b0;
   logic [127:0] rx_data;
   logic         rx_complete;
   logic         busy;

   int errors = 0;
   int checks = 0;

   rx_shift_register #(.DATA_W(128), .CLEN_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .char_len    (char_len),
      .lsb         (lsb),
      .go_busy     (go_busy),
      .miso        (miso),
      .rx_data     (rx_data),
      .rx_complete (rx_complete),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [5:0] clen, input logic l);
      char_len = clen;
      lsb      = l;
      go_busy  = 1'b1;
      tick();
   endtask

   // seq[k] is the k-th bit placed on miso
   task automatic send_bits(input logic [63:0] seq, input int n);
      for (int k = 0; k < n; k++) begin
         miso = seq[k];
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++;
      if (rx_data !== 128'h0) begin errors++; $display("FAIL reset_rx_data got=%h exp=0", rx_data); end
      checks++;
      if (rx_complete !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl got complete=%b busy=%b exp 0 0", rx_complete, busy);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_msb_first();
      logic [63:0] seq;
      int busy_cnt;
      int early;
      seq = 64'h95;
      busy_cnt = 0;
      early = 0;
      start_frame(6'd8, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (busy === 1'b1) busy_cnt++;
         miso = seq[k];
         tick();
         if (k < 7 && rx_complete !== 1'b0) early++;
      end
      checks++;
      if (busy_cnt != 8) begin errors++; $display("FAIL msb_busy_cycles got=%0d exp=8", busy_cnt); end
      checks++;
      if (early != 0) begin errors++; $display("FAIL msb_early_complete got=%0d exp=0", early); end
      checks++;
      if (rx_complete !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL msb_done got complete=%b busy=%b exp 1 0", rx_complete, busy);
      end
      checks++;
      if (rx_data !== 128'hA9) begin errors++; $display("FAIL msb_data got=%h exp=a9", rx_data); end
      go_busy = 1'b0;
      tick();
      checks++;
      if (rx_complete !== 1'b0) begin errors++; $display("FAIL msb_pulse_width got=%b exp=0", rx_complete); end
   endtask

   task automatic test_lsb_first();
      start_frame(6'd8, 1'b1);
      char_len = 6'd3;
      lsb      = 1'b0;
      send_bits(64'h95, 7);
      checks++;
      if (rx_data !== 128'hA9 || rx_complete !== 1'b0) begin
         errors++; $display("FAIL lsb_hold_prev got=%h/%b exp=a9/0", rx_data, rx_complete);
      end
      miso = 1'b1;
      tick();
      checks++;
      if (rx_data !== 128'h95 || rx_complete !== 1'b1) begin
         errors++; $display("FAIL lsb_data got=%h/%b exp=95/1", rx_data, rx_complete);
      end
      go_busy = 1'b0;
      tick();
   endtask

   task automatic test_len64();
      start_frame(6'd0, 1'b0);
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 63);
      checks++;
      if (rx_complete !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL len64_midway got complete=%b busy=%b exp 0 1", rx_complete, busy);
      end
      miso = 1'b1;
      tick();
      checks++;
      if (rx_complete !== 1'b1) begin errors++; $display("FAIL len64_complete got=%b exp=1", rx_complete); end
      checks++;
      if (rx_data !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
         errors++; $display("FAIL len64_data got=%h exp=0000000000000000ffffffffffffffff", rx_data);
      end
      go_busy = 1'b0;
      miso    = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      int pulses;
      pulses = 0;
      start_frame(6'd8, 1'b0);
      send_bits(64'h7, 3);
      go_busy = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      for (int i = 0; i < 8; i++) begin
         if (rx_complete !== 1'b0) pulses++;
         tick();
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL abort_pulse got=%0d exp=0", pulses); end
      checks++;
      if (rx_data !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
         errors++; $display("FAIL abort_keep got=%h exp=ffffffffffffffff", rx_data);
      end
      start_frame(6'd8, 1'b0);
      send_bits(64'h3C, 8);
      checks++;
      if (rx_data !== 128'h3C || rx_complete !== 1'b1) begin
         errors++; $display("FAIL abort_next got=%h/%b exp=3c/1", rx_data, rx_complete);
      end
      go_busy = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int pulses;
      int busy_seen;
      pulses = 0;
      busy_seen = 0;
      start_frame(6'd8, 1'b0);
      for (int i = 0; i < 39; i++) begin
         miso = (i < 8) ? ((8'hA3 >> i) & 1) : 1'b1;
         tick();
         if (rx_complete === 1'b1) pulses++;
         if (i >= 8 && busy !== 1'b0) busy_seen++;
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL hold_pulses got=%0d exp=1", pulses); end
      checks++;
      if (busy_seen != 0) begin errors++; $display("FAIL hold_busy got=%0d exp=0", busy_seen); end
      checks++;
      if (rx_data !== 128'hC5) begin errors++; $display("FAIL hold_data got=%h exp=c5", rx_data); end
      go_busy = 1'b0;
      tick();
      start_frame(6'd8, 1'b0);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", busy); end
      send_bits(64'hF0, 8);
      checks++;
      if (rx_data !== 128'h0F || rx_complete !== 1'b1) begin
         errors++; $display("FAIL restart_data got=%h/%b exp=0f/1", rx_data, rx_complete);
      end
      go_busy = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      start_frame(6'd8, 1'b0);
      send_bits(64'h1F, 5);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rx_data !== 128'h0 || busy !== 1'b0 || rx_complete !== 1'b0) begin
         errors++; $display("FAIL areset_outputs got=%h/%b/%b exp=0/0/0", rx_data, busy, rx_complete);
      end
      go_busy = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      start_frame(6'd8, 1'b0);
      send_bits(64'hA3, 7);
      checks++;
      if (rx_complete !== 1'b0 || rx_data !== 128'h0) begin
         errors++; $display("FAIL areset_partial got=%h/%b exp=0/0", rx_data, rx_complete);
      end
      send_bits(64'h1, 1);
      checks++;
      if (rx_data !== 128'hC5 || rx_complete !== 1'b1) begin
         errors++; $display("FAIL areset_frame got=%h/%b exp=c5/1", rx_data, rx_complete);
      end
      go_busy = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_len64();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
